// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Pipelined immediate-extension unit between decode and the ALU-source mux.
//   Extends an IN_W-bit immediate to OUT_W bits in one of four modes, carries a
//   TAG_W sideband tag with it, and buffers up to two results behind a
//   valid/ready handshake so that ready_o comes straight from a flop.
//
//   Optional feature macro: IMM_EXT_SHL2_EN
//     defined   : mode 3 = sign-extend then shift left by 2 (OUT_W >= IN_W + 2)
//     undefined : no shifter; mode 3 is a plain sign-extend (OUT_W > IN_W)
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; valid may be raised without waiting for ready, and the outputs
//   data_o/tag_o are held stable while valid_o && !ready_i.
//
//   Storage: M (main) drives the outputs, S (skid) holds one extra entry.
//   The state encoding is {M valid, S valid}, so valid_o is state_q[1].

module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [IN_W-1:0]  data_i,
   input  logic [1:0]       mode_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [OUT_W-1:0] data_o,
   output logic [TAG_W-1:0] tag_o
);

   localparam int EXT_W = OUT_W - IN_W;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } state_e;

   state_e            state_q, state_d;
   logic              ready_q, ready_d;
   logic [OUT_W-1:0]  m_data_q, m_data_d;
   logic [TAG_W-1:0]  m_tag_q,  m_tag_d;
   logic [OUT_W-1:0]  s_data_q, s_data_d;
   logic [TAG_W-1:0]  s_tag_q,  s_tag_d;

   logic              accept;
   logic              deliver;

   logic [OUT_W-1:0]  sext_w;
   logic [OUT_W-1:0]  zext_w;
   logic [OUT_W-1:0]  upper_w;
   logic [OUT_W-1:0]  ext_w;

   // The registers hold finished results, so the extension is done here at
   // the input and the output side is pure flops.
   assign sext_w  = {{EXT_W{data_i[IN_W-1]}}, data_i};
   assign zext_w  = {{EXT_W{1'b0}}, data_i};
   assign upper_w = {data_i, {EXT_W{1'b0}}};

`ifdef IMM_EXT_SHL2_EN
   logic [OUT_W-1:0]  shl2_w;
   // Branch-offset form: sign-extend then scale by 4; bits that fall off the
   // top are simply dropped.
   assign shl2_w = {sext_w[OUT_W-3:0], 2'b00};
`endif

   // Select the extension for the mode of the offered transaction.
   always_comb begin
      ext_w = sext_w;
      case (mode_i)
         2'd0: ext_w = sext_w;
         2'd1: ext_w = zext_w;
         2'd2: ext_w = upper_w;
`ifdef IMM_EXT_SHL2_EN
         2'd3: ext_w = shl2_w;
`else
         2'd3: ext_w = sext_w;
`endif
         default: ext_w = sext_w;
      endcase
   end

   assign accept  = valid_i && ready_q;
   assign deliver = state_q[1] && ready_i;

   // Next-state and storage steering for the two-entry skid buffer.
   always_comb begin
      state_d  = state_q;
      m_data_d = m_data_q;
      m_tag_d  = m_tag_q;
      s_data_d = s_data_q;
      s_tag_d  = s_tag_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d  = ST_ONE;
               m_data_d = ext_w;
               m_tag_d  = tag_i;
            end
         end
         ST_ONE: begin
            if (accept && deliver) begin
               // M leaves and the new entry takes its place in the same edge.
               state_d  = ST_ONE;
               m_data_d = ext_w;
               m_tag_d  = tag_i;
            end else if (accept) begin
               state_d  = ST_FULL;
               s_data_d = ext_w;
               s_tag_d  = tag_i;
            end else if (deliver) begin
               // M keeps its contents so data_o/tag_o show the last delivery.
               state_d  = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // ready_o is low here, so only a delivery can happen.
            if (deliver) begin
               state_d  = ST_ONE;
               m_data_d = s_data_q;
               m_tag_d  = s_tag_q;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      ready_d = (state_d != ST_FULL);
   end

   // State, registered ready and the M/S entries; reset clears everything at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_EMPTY;
         ready_q  <= 1'b1;
         m_data_q <= '0;
         m_tag_q  <= '0;
         s_data_q <= '0;
         s_tag_q  <= '0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         m_data_q <= m_data_d;
         m_tag_q  <= m_tag_d;
         s_data_q <= s_data_d;
         s_tag_q  <= s_tag_d;
      end
   end

   assign ready_o = ready_q;
   assign valid_o = state_q[1];
   assign data_o  = m_data_q;
   assign tag_o   = m_tag_q;

endmodule
